udp_tx_framer: RTL

Downstream UDP transmit stage. It grants application send requests and captures the application payload into a local packet buffer. It then asks the IP layer for a send slot and emits the 8-byte UDP header followed by the payload as a byte stream. It is the consumer of the app_tx_* / udp_data_length interface, and the source of udp_tx_ready and app_tx_ack.

---
 rtl/udp_pkg.sv | 43 ++++
 rtl/udp_tx_framer_if.sv | 32 +++
 rtl/udp_tx_buf.sv | 26 ++
 rtl/udp_tx_framer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit framer.
// Header byte order and the header byte selector live here.
package udp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_LOAD,
    ST_IP_REQ,
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  localparam int UDP_HDR_LEN = 8;

  localparam logic [2:0] HDR_SRC_HI  = 3'd0;
  localparam logic [2:0] HDR_SRC_LO  = 3'd1;
  localparam logic [2:0] HDR_DST_HI  = 3'd2;
  localparam logic [2:0] HDR_DST_LO  = 3'd3;
  localparam logic [2:0] HDR_LEN_HI  = 3'd4;
  localparam logic [2:0] HDR_LEN_LO  = 3'd5;
  localparam logic [2:0] HDR_CSUM_HI = 3'd6;
  localparam logic [2:0] HDR_CSUM_LO = 3'd7;

  // Checksum bytes are zero: UDP checksum disabled.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [15:0] src,
                                          input logic [15:0] dst,
                                          input logic [15:0] ulen);
    case (idx)
      HDR_SRC_HI:  return src[15:8];
      HDR_SRC_LO:  return src[7:0];
      HDR_DST_HI:  return dst[15:8];
      HDR_DST_LO:  return dst[7:0];
      HDR_LEN_HI:  return ulen[15:8];
      HDR_LEN_LO:  return ulen[7:0];
      HDR_CSUM_HI: return 8'h00;
      HDR_CSUM_LO: return 8'h00;
      default:     return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/udp_tx_framer_if.sv
// Application and IP-layer signals of the UDP transmit framer.
// master = application/IP environment, slave = framer.
interface udp_tx_framer_if;
  logic [15:0] local_port;
  logic [15:0] remote_port;
  logic        udp_tx_ready;
  logic        app_tx_data_request;
  logic [15:0] udp_data_length;
  logic        app_tx_ack;
  logic        app_tx_data_valid;
  logic [7:0]  app_tx_data;
  logic        ip_tx_ready;
  logic        ip_tx_request;
  logic        ip_tx_ack;
  logic [15:0] ip_tx_length;
  logic        ip_tx_data_valid;
  logic [7:0]  ip_tx_data;

  modport master (
    output local_port, remote_port, app_tx_data_request, udp_data_length,
           app_tx_data_valid, app_tx_data, ip_tx_ready, ip_tx_ack,
    input  udp_tx_ready, app_tx_ack, ip_tx_request, ip_tx_length,
           ip_tx_data_valid, ip_tx_data
  );

  modport slave (
    input  local_port, remote_port, app_tx_data_request, udp_data_length,
           app_tx_data_valid, app_tx_data, ip_tx_ready, ip_tx_ack,
    output udp_tx_ready, app_tx_ack, ip_tx_request, ip_tx_length,
           ip_tx_data_valid, ip_tx_data
  );
endinterface

// File: rtl/udp_tx_buf.sv
// Payload buffer: simple dual-port byte RAM with registered read,
// written while loading and read while streaming the payload.
module udp_tx_buf #(
  parameter int MAX_LEN = 256,
  localparam int AW = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_tx_framer.sv
// UDP transmit framer: grants an application send, buffers the payload,
// then emits the 8-byte UDP header plus payload towards the IP layer.
module udp_tx_framer
  import udp_pkg::*;
#(
  parameter int MAX_LEN      = 256,
  parameter int LOAD_TIMEOUT = 1024
) (
  input logic         clk,
  input logic         rst_n,
  udp_tx_framer_if.slave bus
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(LOAD_TIMEOUT) + 1;

  function automatic logic [15:0] clamp_len(input logic [15:0] raw);
    return (raw > 16'(MAX_LEN)) ? 16'(MAX_LEN) : raw;
  endfunction

  state_t          state, state_nxt;
  logic [15:0]     len, src_port, dst_port, ip_len;
  logic [CW-1:0]   wr_cnt, rd_cnt;
  logic [TW-1:0]   idle_cnt;
  logic [2:0]      hdr_idx;
  logic            ip_req, ready_q, ack_q;
  logic            last_wr, last_rd, timeout, grant;
  logic            wr_en, rd_en;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      rd_data;
  logic            out_vld;
  logic [7:0]      out_dat;

  assign last_wr = bus.app_tx_data_valid && (16'(wr_cnt) == len - 16'd1);
  assign last_rd = (16'(rd_cnt) == len - 16'd1);
  assign timeout = !bus.app_tx_data_valid && (idle_cnt == TW'(LOAD_TIMEOUT - 1));
  assign grant   = ip_req && bus.ip_tx_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.app_tx_data_request) state_nxt = ST_ACK;
      ST_ACK:     state_nxt = (len == 16'd0) ? ST_IP_REQ : ST_LOAD;
      ST_LOAD: begin
        if (last_wr)      state_nxt = ST_IP_REQ;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_IP_REQ:  if (grant) state_nxt = ST_HEADER;
      ST_HEADER: begin
        if (hdr_idx == HDR_CSUM_LO)
          state_nxt = (len == 16'd0) ? ST_IDLE : ST_PAYLOAD;
      end
      ST_PAYLOAD: if (last_rd) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      ack_q    <= 1'b0;
      ip_req   <= 1'b0;
      ip_len   <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      idle_cnt <= '0;
      hdr_idx  <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_IDLE);
      ack_q   <= (state_nxt == ST_ACK);
      case (state)
        ST_IDLE: begin
          if (bus.app_tx_data_request)
            ip_len <= clamp_len(bus.udp_data_length) + 16'(UDP_HDR_LEN);
        end
        ST_ACK: begin
          wr_cnt   <= '0;
          idle_cnt <= '0;
        end
        ST_LOAD: begin
          if (bus.app_tx_data_valid) begin
            wr_cnt   <= wr_cnt + CW'(1);
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        ST_IP_REQ: begin
          // Request waits for an idle IP layer, then holds until granted.
          if (grant) begin
            ip_req  <= 1'b0;
            hdr_idx <= '0;
          end else if (bus.ip_tx_ready) begin
            ip_req  <= 1'b1;
          end
        end
        ST_HEADER: begin
          hdr_idx <= hdr_idx + 3'd1;
          rd_cnt  <= '0;
        end
        ST_PAYLOAD: rd_cnt <= rd_cnt + CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.app_tx_data_request) begin
      len      <= clamp_len(bus.udp_data_length);
      src_port <= bus.local_port;
      dst_port <= bus.remote_port;
    end
  end

  // Read address runs one byte ahead of the byte on the output.
  assign wr_en   = (state == ST_LOAD) && bus.app_tx_data_valid;
  assign rd_en   = ((state == ST_HEADER) && (hdr_idx == HDR_CSUM_LO)) ||
                   ((state == ST_PAYLOAD) && !last_rd);
  assign rd_addr = (state == ST_HEADER) ? '0 : AW'(rd_cnt + CW'(1));

  udp_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt[AW-1:0]),
    .wr_data (bus.app_tx_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    out_vld = 1'b0;
    out_dat = 8'h00;
    case (state)
      ST_HEADER: begin
        out_vld = 1'b1;
        out_dat = hdr_byte(hdr_idx, src_port, dst_port, ip_len);
      end
      ST_PAYLOAD: begin
        out_vld = 1'b1;
        out_dat = rd_data;
      end
      default: ;
    endcase
  end

  assign bus.udp_tx_ready     = ready_q;
  assign bus.app_tx_ack       = ack_q;
  assign bus.ip_tx_request    = ip_req;
  assign bus.ip_tx_length     = ip_len;
  assign bus.ip_tx_data_valid = out_vld;
  assign bus.ip_tx_data       = out_dat;

endmodule
